in_bus_router: RTL and testbench
================================

Name: in_bus_router

Overview:
- Parametrised successor of the input bus: accepts host register-access requests and packs each into a frame {reg_addr, wr_rd, wr_data, op_id}.
- Routes each frame to the switch FIFO selected by the upper address bits.
- Adds the following over the previous generation:
  - a HOLD_DEPTH-entry in-order holding queue
  - per-switch FIFO backpressure (fifo_full)
  - a ready handshake to the host
  - detection and counting of requests to non-existent switches
- Sits between the host request interface and the NUM_SW_INST switch input FIFOs.

Parameters:
- NUM_SW_INST, 5, number of switch instances/FIFOs; must be <= 2**SW_ADDR_W.
- SW_ADDR_W, 3, switch-select field width: addr_in[ADDR_W-1 -: SW_ADDR_W].
- REG_ADDR_W, 5, register-address field width: addr_in[REG_ADDR_W-1:0].
- ADDR_W, 8, addr_in width; must equal SW_ADDR_W+REG_ADDR_W.
- W_WIDTH, 8, write-data width.
- OP_ID_W, 8, operation-ID width.
- FRAME_WIDTH, 32, frame width; must be >= REG_ADDR_W+1+W_WIDTH+OP_ID_W. Unused MSBs are zero.
- HOLD_DEPTH, 4, holding-queue entries; power of two, >= 2.
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- en_in  in  1  bus enable; a request is considered only when high.
- valid  in  1  request valid.
- wr_rd_op  in  1  1 = write, 0 = read.
- op_id  in  OP_ID_W  operation identifier.
- addr_in  in  ADDR_W  {switch index, register address}.
- wr_data_in  in  W_WIDTH  write data.
- fifo_full  in  NUM_SW_INST  bit i high: switch FIFO i cannot accept a write this cycle.
- ready  out  1  queue has space; a function of registered state only.
- frame_out  out  FRAME_WIDTH  frame being written; zero when no write.
- fifo_wr_en  out  NUM_SW_INST  one-hot write strobe, single-cycle per frame.
- addr_err  out  1  one-cycle pulse: an accepted request targeted switch index >= NUM_SW_INST.
- err_cnt  out  ERR_CNT_W  saturating count of addr_err events.
- busy  out  1  queue non-empty or output write in flight.

Behaviour:
- Reset (rst=1 at posedge):
  - queue emptied (head, tail, count = 0)
  - frame_out = 0, fifo_wr_en = 0, addr_err = 0, err_cnt = 0
  - ready = 1, busy = 0
  - Reset mid-operation discards all queued frames with no strobe.
- Accept:
  - A request is accepted in a cycle when en_in && valid && ready.
  - If en_in=0 or valid=0, nothing is accepted and no error is raised.
- Frame packing: frame = {zeros, addr_in[REG_ADDR_W-1:0], wr_rd_op, wr_data_in, op_id}, with op_id in the LSBs.
  - Defaults give bits [21:17] addr, [16] wr_rd, [15:8] data, [7:0] op_id.
- Valid target (index < NUM_SW_INST): {index, frame} pushed at tail on the accepting edge.
- Invalid target (index >= NUM_SW_INST):
  - Request is consumed and not queued.
  - addr_err = 1 for the cycle after acceptance.
  - err_cnt increments and saturates at 2**ERR_CNT_W-1.
- ready = (count < HOLD_DEPTH).
  - When full, no push occurs even if a pop happens in the same cycle; ready rises the cycle after the pop.
- Issue (registered output stage), each cycle:
  - Condition: count > 0 and fifo_full[head.index] = 0.
  - If met: on the next edge frame_out <= head.frame, fifo_wr_en <= onehot(head.index), head pops.
  - Otherwise: frame_out <= 0, fifo_wr_en <= 0.
- Ordering:
  - Strict FIFO order with head-of-line blocking; a full target stalls all later frames even if their targets are free.
  - fifo_full is sampled in the issue-decision cycle only.
- Latency: accept edge E puts the entry in the queue; with an empty queue and target not full, the strobe is visible after edge E+1 (2 cycles from request to strobe).
- Throughput: one accept and one issue per cycle. Push and pop in the same cycle leave count unchanged, with wrap-around of the head/tail pointers modulo HOLD_DEPTH.
- busy = (count != 0) || (fifo_wr_en != 0).

Test Plan:
- Single write: addr_in=8'h43, wr_rd_op=1, wr_data_in=8'hA5, op_id=8'h17, fifo_full=0 -> two edges later fifo_wr_en=5'b00100 for one cycle and frame_out=32'h0007A517; both zero the next cycle.
- Backpressure: fifo_full[1]=1, send 5 requests to switch 1 -> 4 accepted, ready=0 on the 5th, no strobe. Release fifo_full[1] -> 4 strobes on consecutive cycles in order of op_id; ready returns to 1.
- Head-of-line blocking: queue frames to switch 2 then switch 0 with fifo_full[2]=1 -> no strobe to switch 0 until fifo_full[2] drops; then switch 2 is strobed before switch 0.
- Invalid address: addr_in=8'hE0 (index 7) accepted -> addr_err pulses one cycle, err_cnt=1, no fifo_wr_en. Repeat 300 times with ERR_CNT_W=8 -> err_cnt saturates at 255.
- Enable gating plus pointer wrap: valid=1 with en_in=0 -> no accept, no error. Stream 10 back-to-back requests to rotating switches 0..4 with fifo_full=0 -> 10 strobes, one per cycle, in order, correct one-hot each.
- Reset mid-operation: rst=1 with 3 frames queued -> next cycle fifo_wr_en=0, frame_out=0, busy=0, ready=1, err_cnt=0; no queued frame is ever emitted afterwards.

Source files
------------

// File: rtl/in_bus_router.sv
// rtl/in_bus_router.sv - host request packer and in-order router to switch FIFOs
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en_in       : bus enable
//   valid       : request valid
//   wr_rd_op    : 1 = write, 0 = read
//   op_id       : operation identifier
//   addr_in     : {switch index, register address}
//   wr_data_in  : write data
//   fifo_full   : per-switch FIFO full
//   ready       : holding queue has space
//   frame_out   : frame being written (zero when idle)
//   fifo_wr_en  : one-hot write strobe
//   addr_err    : pulse after accepting a request to a non-existent switch
//   err_cnt     : saturating count of addr_err events
//   busy        : queue non-empty or write in flight
module in_bus_router #(
  parameter int NUM_SW_INST = 5,
  parameter int SW_ADDR_W   = 3,
  parameter int REG_ADDR_W  = 5,
  parameter int ADDR_W      = 8,
  parameter int W_WIDTH     = 8,
  parameter int OP_ID_W     = 8,
  parameter int FRAME_WIDTH = 32,
  parameter int HOLD_DEPTH  = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic                   valid,
  input  logic                   wr_rd_op,
  input  logic [OP_ID_W-1:0]     op_id,
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic [W_WIDTH-1:0]     wr_data_in,
  input  logic [NUM_SW_INST-1:0] fifo_full,
  output logic                   ready,
  output logic [FRAME_WIDTH-1:0] frame_out,
  output logic [NUM_SW_INST-1:0] fifo_wr_en,
  output logic                   addr_err,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic                   busy
);

  localparam int PTR_W    = $clog2(HOLD_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int SW_SPACE = 1 << SW_ADDR_W;
  localparam logic [SW_ADDR_W:0] NUM_SW_L = (SW_ADDR_W + 1)'(NUM_SW_INST);
  localparam logic [CNT_W-1:0]   DEPTH_L  = CNT_W'(HOLD_DEPTH);

  // Queue storage: switch index and packed frame per entry.
  logic [SW_ADDR_W-1:0]   idx_mem   [HOLD_DEPTH];
  logic [FRAME_WIDTH-1:0] frame_mem [HOLD_DEPTH];

  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FRAME_WIDTH-1:0] frame_out_q, frame_out_d;
  logic [NUM_SW_INST-1:0] fifo_wr_en_q, fifo_wr_en_d;
  logic                   addr_err_q, addr_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [SW_ADDR_W-1:0]   sw_idx;
  logic                   idx_ok;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [FRAME_WIDTH-1:0] new_frame;
  logic [SW_SPACE-1:0]    full_pad;
  logic [SW_ADDR_W-1:0]   head_idx;

  assign sw_idx    = addr_in[ADDR_W-1 -: SW_ADDR_W];
  assign idx_ok    = {1'b0, sw_idx} < NUM_SW_L;
  assign new_frame = FRAME_WIDTH'({addr_in[REG_ADDR_W-1:0], wr_rd_op, wr_data_in, op_id});

  // ready depends on registered count only, so a pop cannot free a slot in the same cycle.
  assign ready  = count_q < DEPTH_L;
  assign accept = en_in && valid && ready;
  assign push   = accept && idx_ok;

  // Pad fifo_full to the full index space so the head lookup is always in range.
  assign full_pad = SW_SPACE'(fifo_full);
  assign head_idx = idx_mem[head_q];
  assign pop      = (count_q != '0) && !full_pad[head_idx];

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    frame_out_d  = '0;
    fifo_wr_en_d = '0;
    addr_err_d   = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (pop) begin
      frame_out_d  = frame_mem[head_q];
      fifo_wr_en_d = NUM_SW_INST'(1) << head_idx;
      head_d       = head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (accept && !idx_ok) begin
      addr_err_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      frame_out_q  <= '0;
      fifo_wr_en_q <= '0;
      addr_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      frame_out_q  <= frame_out_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      addr_err_q   <= addr_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q covers them.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      idx_mem[tail_q]   <= sw_idx;
      frame_mem[tail_q] <= new_frame;
    end
  end

  assign frame_out  = frame_out_q;
  assign fifo_wr_en = fifo_wr_en_q;
  assign addr_err   = addr_err_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = (count_q != '0) || (fifo_wr_en_q != '0);

endmodule

// File: tb/tb_in_bus_router.sv
// tb/tb_in_bus_router.sv - directed self-checking bench for in_bus_router
module tb_in_bus_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic        valid;
  logic        wr_rd_op;
  logic [7:0]  op_id;
  logic [7:0]  addr_in;
  logic [7:0]  wr_data_in;
  logic [4:0]  fifo_full;
  logic        ready;
  logic [31:0] frame_out;
  logic [4:0]  fifo_wr_en;
  logic        addr_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  in_bus_router dut (
    .clk        (clk),
    .rst        (rst),
    .en_in      (en_in),
    .valid      (valid),
    .wr_rd_op   (wr_rd_op),
    .op_id      (op_id),
    .addr_in    (addr_in),
    .wr_data_in (wr_data_in),
    .fifo_full  (fifo_full),
    .ready      (ready),
    .frame_out  (frame_out),
    .fifo_wr_en (fifo_wr_en),
    .addr_err   (addr_err),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge, then sit 1ns past it for sampling and driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_frame(input logic [4:0] ra, input logic wr,
                                           input logic [7:0] d, input logic [7:0] id);
    return {10'b0, ra, wr, d, id};
  endfunction

  task automatic drive(input logic [7:0] a, input logic wr, input logic [7:0] d, input logic [7:0] id);
    en_in = 1'b1; valid = 1'b1; addr_in = a; wr_rd_op = wr; wr_data_in = d; op_id = id;
  endtask

  task automatic idle();
    valid = 1'b0;
  endtask

  logic [31:0] exp_frame [10];
  logic [4:0]  exp_oh    [10];

  initial begin
    rst = 1'b1; en_in = 1'b0; valid = 1'b0; wr_rd_op = 1'b0;
    op_id = '0; addr_in = '0; wr_data_in = '0; fifo_full = '0;
    tick(); tick();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_frame", frame_out, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    tick();

    // Single write to switch 2
    drive(8'h43, 1'b1, 8'hA5, 8'h17);
    tick(); idle();
    chk("sw_no_strobe_yet", fifo_wr_en, 0);
    chk("sw_busy", busy, 1);
    tick();
    chk("sw_wr_en", fifo_wr_en, 5'b00100);
    chk("sw_frame", frame_out, 32'h0007A517);
    tick();
    chk("sw_wr_en_clear", fifo_wr_en, 0);
    chk("sw_frame_clear", frame_out, 0);
    chk("sw_busy_clear", busy, 0);

    // Backpressure on switch 1: 4 fit, 5th refused
    fifo_full = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      drive(8'h20 | 8'(i), 1'b1, 8'h50 + 8'(i), 8'h30 + 8'(i));
      chk("bp_ready_pre", ready, (i < 4) ? 1 : 0);
      tick();
      chk("bp_no_strobe", fifo_wr_en, 0);
    end
    idle();
    tick();
    chk("bp_held", fifo_wr_en, 0);
    chk("bp_full", ready, 0);
    fifo_full = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_wr_en", fifo_wr_en, 5'b00010);
      chk("bp_frame", frame_out, mk_frame(5'(i), 1'b1, 8'h50 + 8'(i), 8'h30 + 8'(i)));
      chk("bp_ready_back", ready, 1);
    end
    tick();
    chk("bp_done", fifo_wr_en, 0);
    chk("bp_busy", busy, 0);

    // Head-of-line blocking
    fifo_full = 5'b00100;
    drive(8'h41, 1'b0, 8'h11, 8'h61); tick();
    drive(8'h02, 1'b1, 8'h22, 8'h62); tick(); idle();
    tick(); tick();
    chk("hol_blocked", fifo_wr_en, 0);
    chk("hol_busy", busy, 1);
    fifo_full = 5'b00000;
    tick();
    chk("hol_first_en", fifo_wr_en, 5'b00100);
    chk("hol_first_frame", frame_out, mk_frame(5'd1, 1'b0, 8'h11, 8'h61));
    tick();
    chk("hol_second_en", fifo_wr_en, 5'b00001);
    chk("hol_second_frame", frame_out, mk_frame(5'd2, 1'b1, 8'h22, 8'h62));
    tick();
    chk("hol_done", fifo_wr_en, 0);

    // Invalid switch index
    drive(8'hE0, 1'b1, 8'h00, 8'h70);
    tick(); idle();
    chk("inv_err", addr_err, 1);
    chk("inv_cnt", err_cnt, 1);
    chk("inv_busy", busy, 0);
    tick();
    chk("inv_err_clear", addr_err, 0);
    chk("inv_no_strobe", fifo_wr_en, 0);
    drive(8'hE0, 1'b1, 8'h00, 8'h71);
    for (int i = 0; i < 300; i++) tick();
    idle();
    chk("inv_saturate", err_cnt, 255);
    tick();
    chk("inv_sat_err_clear", addr_err, 0);
    chk("inv_sat_hold", err_cnt, 255);

    // Enable gating
    drive(8'h00, 1'b1, 8'h33, 8'h90); en_in = 1'b0;
    tick();
    chk("en_busy", busy, 0);
    addr_in = 8'hE0;
    tick();
    chk("en_no_err", addr_err, 0);
    chk("en_no_strobe", fifo_wr_en, 0);
    idle();

    // Back-to-back stream with pointer wrap
    for (int i = 0; i < 10; i++) begin
      exp_frame[i] = mk_frame(5'(i), 1'(i), 8'hC0 + 8'(i), 8'h80 + 8'(i));
      exp_oh[i]    = 5'b00001 << (i % 5);
    end
    for (int i = 0; i < 10; i++) begin
      drive({3'(i % 5), 5'(i)}, 1'(i), 8'hC0 + 8'(i), 8'h80 + 8'(i));
      tick();
      if (i >= 1) begin
        chk("st_wr_en", fifo_wr_en, exp_oh[i-1]);
        chk("st_frame", frame_out, exp_frame[i-1]);
      end
    end
    idle();
    tick();
    chk("st_last_en", fifo_wr_en, exp_oh[9]);
    chk("st_last_frame", frame_out, exp_frame[9]);
    tick();
    chk("st_done", fifo_wr_en, 0);
    chk("st_busy", busy, 0);

    // Reset with frames queued
    fifo_full = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      drive(8'h60 | 8'(i), 1'b1, 8'hD0, 8'hA0 + 8'(i));
      tick();
    end
    idle();
    chk("rm_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    chk("rm_wr_en", fifo_wr_en, 0);
    chk("rm_frame", frame_out, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ready", ready, 1);
    chk("rm_err_cnt", err_cnt, 0);
    rst = 1'b0;
    fifo_full = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_no_emit", fifo_wr_en, 0);
      chk("rm_idle", busy, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
